trafficgen_axil_regbank: RTL

- Parametrised AXI4-Lite slave register bank; next-generation control/status front end for the trafficgen IP.
- Provides NUM_REGS read/write registers with byte strobes.
- AW and W channels are accepted independently, in either order.
- Drives a flattened register bus and per-register write pulses to the traffic engine.
- Sits directly behind the AXI interconnect / master VIP in the block design.

---
 rtl/trafficgen_axil_regbank.sv | 132 +++++++++++++
 1 files changed

// File: rtl/trafficgen_axil_regbank.sv
// trafficgen_axil_regbank: AXI4-Lite slave register bank with byte strobes, flattened register bus and write pulses.
// Define TRAFFICGEN_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module trafficgen_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 8,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] REG_RESET_VAL = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int OFS = $clog2(SW);
  localparam int IW = C_S_AXI_ADDR_WIDTH - OFS;
`ifdef TRAFFICGEN_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  logic                          rst_done_q, aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [IW-1:0]                 aw_idx_q, ar_idx;
  logic [DW-1:0]                 wdata_q, rdata_q, rdata_d;
  logic [SW-1:0]                 wstrb_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [NUM_REGS-1:0][DW-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
  logic                          aw_hs, w_hs, ar_hs, commit, aw_hit, ar_hit;
  logic                          unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFS-1:0], S_AXI_ARADDR[OFS-1:0]};
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:OFS];
  assign S_AXI_AWREADY = rst_done_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY = rst_done_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held_q & w_held_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign reg_out = regs_q;
  assign wr_pulse = wr_pulse_q;
  // Indices that match no register fall through as out-of-range: no update, zero read data.
  always_comb begin
    regs_d = regs_q;
    wr_pulse_d = '0;
    rdata_d = '0;
    aw_hit = 1'b0;
    ar_hit = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (aw_idx_q == IW'(n)) begin
        aw_hit = 1'b1;
        wr_pulse_d[n] = commit;
        for (int b = 0; b < SW; b++)
          if (commit && wstrb_q[b]) regs_d[n][8*b +: 8] = wdata_q[8*b +: 8];
      end
      if (ar_idx == IW'(n)) begin
        ar_hit = 1'b1;
        rdata_d = regs_q[n];
      end
    end
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      regs_q <= {NUM_REGS{REG_RESET_VAL}};
      wr_pulse_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      regs_q <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFS];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      // Both flags set implies BVALID is low, so commit never collides with a pending response.
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q <= aw_hit ? 2'b00 : OOR_RESP;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q <= rdata_d;
        rresp_q <= ar_hit ? 2'b00 : OOR_RESP;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule
